mult_rs: RTL and testbench
==========================

Name: mult_rs

Overview:
- Reservation station feeding the multiply functional unit.
- Accepts dispatched multiply ops carrying ROB-tagged source dependencies, snoops the CDB to capture pending operands, and issues ready ops oldest-first.
- Drives the FU input side: input_transmit, operand, depvals, wbs, flags, robid. Honours the FU busy output.

Parameters:
DEPTH, 4, number of station entries (2..8).
TAG_W, 4, ROB id / CDB tag width.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-low reset.
flush  input  1  synchronous; discards all entries.
disp_valid  input  1  dispatch request.
disp_ready  output  1  station can accept (not full).
disp_operand  input  8  opcode/operand byte.
disp_src_rdy  input  2  per-source operand already available.
disp_src_tag  input  2x4  per-source producing ROB id when not available.
disp_src_val  input  2x8  per-source value when available.
disp_wbs  input  8  writeback selector.
disp_flags  input  8  flags; bit7 = no CDB write.
disp_robid  input  4  destination ROB id.
cdb_valid  input  1  CDB broadcast valid.
cdb_id  input  4  broadcast ROB id.
cdb_val  input  8  broadcast value.
fu_busy  input  1  FU busy.
input_transmit  output  1  issue strobe to FU.
operand  output  8  issued operand.
depvals  output  2x8  issued source values; [0]=a, [1]=b.
wbs  output  8  issued wbs.
flags  output  8  issued flags.
robid  output  4  issued ROB id.
count  output  clog2(DEPTH+1)  valid entry count.

Behaviour:
- Reset (rst low, async): all entries invalid; input_transmit=0; operand, depvals, wbs, flags, robid=0; count=0; disp_ready=1.
- Storage: compacting age-ordered queue; entry 0 is oldest. New entries are written at index count. On issue, entries above the issued slot shift down one.
- Entry fields: valid, operand, wbs, flags, robid, and per source {rdy, tag, val}.
- disp_ready = (count != DEPTH), combinational. Accept happens when disp_valid && disp_ready. A same-cycle issue does not free space for that cycle's dispatch.
- CDB capture: on each edge with cdb_valid, every valid entry source with rdy=0 and tag==cdb_id loads val=cdb_val and sets rdy=1. Both sources of one entry may match in the same cycle.
- Dispatch/CDB race: if a dispatched source has rdy=0 and tag==cdb_id with cdb_valid in the accept cycle, it is written as rdy=1 with val=cdb_val.
- Issue eligibility: entry valid, both rdy bits set as registered state, fu_busy=0, input_transmit=0, flush=0.
  - The input_transmit=0 term is required because the FU raises busy only one cycle after sampling the strobe.
- Issue selection: the lowest-index eligible entry. At the edge, the output regs load that entry's fields, input_transmit is set to 1 for exactly one cycle, and the entry is removed.
- Output hold: outputs hold their last issued values while input_transmit=0.
- Latency: both operands ready at dispatch, FU idle gives dispatch edge E, input_transmit high after edge E+1.
  - A CDB wake at edge W allows issue at earliest edge W+1.
  - Back-to-back issue needs at least 2 cycles spacing.
- Simultaneous dispatch and issue: compaction is applied first, then the new entry is written at count-1. count is unchanged.
- Flush: at the edge, all entries are invalidated, count=0, and input_transmit=0. flush has priority over dispatch and issue. Output data regs are not cleared.
- Reset mid-operation: immediate clear as above. A pending strobe is dropped.

Optional Feature:
MULTRS_WAKE_BYPASS_EN
- Defined: an entry whose only missing operand(s) match the current CDB broadcast is eligible in that same cycle. The issued depvals take cdb_val for the matching sources. Wake-to-issue drops to 0 cycles. The selection still uses lowest index.
- Undefined: a registered rdy is required (1-cycle wake-to-issue), as above.

Test Plan:
- Dispatch {operand=0x05, srcs rdy, vals 3 and 7, robid=2, wbs=0x11, flags=0x00}, fu_busy=0 -> input_transmit pulses once, 1 cycle after accept, with depvals={3,7}, robid=2, wbs=0x11; count returns to 0.
- Dispatch entry with src1 tag=6 not ready; 3 cycles later cdb_valid, id=6, val=0x2A -> capture; issue next edge with depvals[1]=0x2A (same edge if MULTRS_WAKE_BYPASS_EN); a CDB with id=5 causes no capture.
- Fill 4 ready entries with fu_busy=1 -> disp_ready=0 and count=4; a 5th dispatch is not accepted; release fu_busy -> issue robids in dispatch order, with input_transmit never high on consecutive cycles.
- Older entry waiting on tag 9 and younger entry ready -> younger issues first; older issues after a CDB with id=9.
- Dispatch with src0 tag=3 while cdb_valid, id=3, val=0x40 in the same cycle -> entry stored ready; issues with depvals[0]=0x40.
- 3 entries valid, assert flush for one cycle -> count=0, disp_ready=1, no input_transmit; async rst low mid-issue -> input_transmit drops immediately.

Source files
------------

// File: rtl/mult_rs_if.sv
// Signal bundle between the multiply reservation station and its environment:
// dispatch port, CDB snoop, and the FU issue side.
interface mult_rs_if #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                  flush;
   logic                  disp_valid;
   logic                  disp_ready;
   logic [7:0]            disp_operand;
   logic [1:0]            disp_src_rdy;
   logic [1:0][TAG_W-1:0] disp_src_tag;
   logic [1:0][7:0]       disp_src_val;
   logic [7:0]            disp_wbs;
   logic [7:0]            disp_flags;
   logic [TAG_W-1:0]      disp_robid;
   logic                  cdb_valid;
   logic [TAG_W-1:0]      cdb_id;
   logic [7:0]            cdb_val;
   logic                  fu_busy;
   logic                  input_transmit;
   logic [7:0]            operand;
   logic [1:0][7:0]       depvals;
   logic [7:0]            wbs;
   logic [7:0]            flags;
   logic [TAG_W-1:0]      robid;
   logic [CW-1:0]         count;

   modport slave (
      input  flush, disp_valid, disp_operand, disp_src_rdy, disp_src_tag,
             disp_src_val, disp_wbs, disp_flags, disp_robid,
             cdb_valid, cdb_id, cdb_val, fu_busy,
      output disp_ready, input_transmit, operand, depvals, wbs, flags,
             robid, count
   );

   modport master (
      output flush, disp_valid, disp_operand, disp_src_rdy, disp_src_tag,
             disp_src_val, disp_wbs, disp_flags, disp_robid,
             cdb_valid, cdb_id, cdb_val, fu_busy,
      input  disp_ready, input_transmit, operand, depvals, wbs, flags,
             robid, count
   );
endinterface

// File: rtl/mult_rs.sv
// Multiply reservation station: compacting age-ordered queue, CDB operand capture,
// oldest-ready issue. Define MULTRS_WAKE_BYPASS_EN for same-cycle CDB wake-to-issue.
module mult_rs #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic      clk,
   input  logic      rst,
   mult_rs_if.slave  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic                  vld;
      logic [7:0]            op;
      logic [7:0]            wbs;
      logic [7:0]            flags;
      logic [TAG_W-1:0]      robid;
      logic [1:0]            rdy;
      logic [1:0][TAG_W-1:0] tag;
      logic [1:0][7:0]       val;
   } entry_t;

   entry_t           r_ent [DEPTH];
   entry_t           w_cap [DEPTH];
   entry_t           w_nxt [DEPTH];
   entry_t           w_new;
   logic [CW-1:0]    r_count;
   logic             r_xmit;
   logic [7:0]       r_operand;
   logic [1:0][7:0]  r_depvals;
   logic [7:0]       r_wbs;
   logic [7:0]       r_flags;
   logic [TAG_W-1:0] r_robid;
   logic [DEPTH-1:0] w_elig;
   logic             w_go;
   logic             w_issue;
   logic             w_acc;
   logic [IW-1:0]    w_sel;
   logic [IW-1:0]    w_widx;

   assign bus.disp_ready = (r_count != CW'(DEPTH));
   assign w_acc          = bus.disp_valid && bus.disp_ready;
   // The FU only raises busy a cycle after seeing the strobe, so our own strobe blocks issue too.
   assign w_go           = !bus.fu_busy && !r_xmit && !bus.flush;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_cap[i] = r_ent[i];
         for (int s = 0; s < 2; s++) begin
            if (bus.cdb_valid && r_ent[i].vld && !r_ent[i].rdy[s] &&
                r_ent[i].tag[s] == bus.cdb_id) begin
               w_cap[i].rdy[s] = 1'b1;
               w_cap[i].val[s] = bus.cdb_val;
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elig
`ifdef MULTRS_WAKE_BYPASS_EN
         assign w_elig[gi] = r_ent[gi].vld && (&w_cap[gi].rdy);
`else
         assign w_elig[gi] = r_ent[gi].vld && (&r_ent[gi].rdy);
`endif
      end
   endgenerate

   always_comb begin
      w_issue = 1'b0;
      w_sel   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (w_go && w_elig[i]) begin
            w_issue = 1'b1;
            w_sel   = IW'(i);
         end
      end
   end

   // A source arriving on the CDB in the accept cycle is stored already captured.
   always_comb begin
      w_new.vld   = 1'b1;
      w_new.op    = bus.disp_operand;
      w_new.wbs   = bus.disp_wbs;
      w_new.flags = bus.disp_flags;
      w_new.robid = bus.disp_robid;
      w_new.tag   = bus.disp_src_tag;
      w_new.rdy   = bus.disp_src_rdy;
      w_new.val   = bus.disp_src_val;
      for (int s = 0; s < 2; s++) begin
         if (bus.cdb_valid && !bus.disp_src_rdy[s] && bus.disp_src_tag[s] == bus.cdb_id) begin
            w_new.rdy[s] = 1'b1;
            w_new.val[s] = bus.cdb_val;
         end
      end
   end

   assign w_widx = w_issue ? IW'(r_count - CW'(1)) : IW'(r_count);

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         w_nxt[i] = w_cap[i];
      if (w_issue) begin
         for (int i = 0; i < DEPTH - 1; i++)
            if (i >= int'(w_sel))
               w_nxt[i] = w_cap[i + 1];
         w_nxt[DEPTH-1].vld = 1'b0;
      end
      if (w_acc)
         w_nxt[w_widx] = w_new;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            r_ent[i] <= '0;
         r_count   <= '0;
         r_xmit    <= 1'b0;
         r_operand <= '0;
         r_depvals <= '0;
         r_wbs     <= '0;
         r_flags   <= '0;
         r_robid   <= '0;
      end else if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++)
            r_ent[i].vld <= 1'b0;
         r_count <= '0;
         r_xmit  <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            r_ent[i] <= w_nxt[i];
         r_count <= r_count + CW'(w_acc) - CW'(w_issue);
         r_xmit  <= w_issue;
         if (w_issue) begin
            r_operand <= w_cap[w_sel].op;
            r_depvals <= w_cap[w_sel].val;
            r_wbs     <= w_cap[w_sel].wbs;
            r_flags   <= w_cap[w_sel].flags;
            r_robid   <= w_cap[w_sel].robid;
         end
      end
   end

   assign bus.input_transmit = r_xmit;
   assign bus.operand        = r_operand;
   assign bus.depvals        = r_depvals;
   assign bus.wbs            = r_wbs;
   assign bus.flags          = r_flags;
   assign bus.robid          = r_robid;
   assign bus.count          = r_count;
endmodule

// File: tb/tb_mult_rs.sv
// Directed bench for mult_rs: issue latency, CDB wake, ordering, full queue, flush, async reset.
module tb_mult_rs;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   k;
   logic prev_x;
   int   exp_ids [4] = '{8, 9, 10, 11};

   mult_rs_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
   mult_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_disp(input logic [7:0] op, input logic [1:0] srdy,
                           input logic [3:0] t0, input logic [3:0] t1,
                           input logic [7:0] v0, input logic [7:0] v1,
                           input logic [7:0] wb, input logic [7:0] fl,
                           input logic [3:0] rid);
      bus.disp_valid      = 1'b1;
      bus.disp_operand    = op;
      bus.disp_src_rdy    = srdy;
      bus.disp_src_tag[0] = t0;
      bus.disp_src_tag[1] = t1;
      bus.disp_src_val[0] = v0;
      bus.disp_src_val[1] = v1;
      bus.disp_wbs        = wb;
      bus.disp_flags      = fl;
      bus.disp_robid      = rid;
   endtask

   task automatic set_cdb(input logic v, input logic [3:0] id, input logic [7:0] val);
      bus.cdb_valid = v;
      bus.cdb_id    = id;
      bus.cdb_val   = val;
   endtask

   always @(posedge clk) begin
      #1;
      if (bus.input_transmit)
         $display("[TB] t=%0t issue robid=%0d op=0x%0h a=0x%0h b=0x%0h wbs=0x%0h flags=0x%0h",
                  $time, bus.robid, bus.operand, bus.depvals[0], bus.depvals[1], bus.wbs, bus.flags);
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.flush = 1'b0;
      bus.fu_busy = 1'b0;
      bus.disp_valid = 1'b0;
      set_disp(8'h0, 2'b00, 4'h0, 4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 4'h0);
      bus.disp_valid = 1'b0;
      set_cdb(1'b0, 4'h0, 8'h0);
      tick();
      tick();
      check("rst_xmit",  32'(bus.input_transmit), 0);
      check("rst_count", 32'(bus.count), 0);
      check("rst_ready", 32'(bus.disp_ready), 1);
      check("rst_robid", 32'(bus.robid), 0);
      check("rst_dep0",  32'(bus.depvals[0]), 0);
      rst = 1'b1;
      tick();

      // Basic issue: both ready, FU idle
      set_disp(8'h05, 2'b11, 4'h0, 4'h0, 8'd3, 8'd7, 8'h11, 8'h00, 4'd2);
      tick();
      bus.disp_valid = 1'b0;
      check("t1_count_acc", 32'(bus.count), 1);
      check("t1_no_xmit_E", 32'(bus.input_transmit), 0);
      tick();
      check("t1_xmit",  32'(bus.input_transmit), 1);
      check("t1_dep_a", 32'(bus.depvals[0]), 3);
      check("t1_dep_b", 32'(bus.depvals[1]), 7);
      check("t1_robid", 32'(bus.robid), 2);
      check("t1_wbs",   32'(bus.wbs), 32'h11);
      check("t1_op",    32'(bus.operand), 32'h05);
      check("t1_count", 32'(bus.count), 0);
      tick();
      check("t1_pulse_end", 32'(bus.input_transmit), 0);
      check("t1_hold",      32'(bus.robid), 2);

      // CDB wake on src1, non-matching id first
      set_disp(8'h06, 2'b01, 4'h0, 4'd6, 8'h01, 8'h00, 8'h22, 8'h80, 4'd4);
      tick();
      bus.disp_valid = 1'b0;
      set_cdb(1'b1, 4'd5, 8'h77);
      tick();
      set_cdb(1'b0, 4'd0, 8'h00);
      check("t2_wait_a", 32'(bus.input_transmit), 0);
      tick();
      check("t2_wait_b", 32'(bus.input_transmit), 0);
      set_cdb(1'b1, 4'd6, 8'h2A);
      tick();
      set_cdb(1'b0, 4'd0, 8'h00);
`ifdef MULTRS_WAKE_BYPASS_EN
      check("t2_xmit_W", 32'(bus.input_transmit), 1);
`else
      check("t2_no_xmit_W", 32'(bus.input_transmit), 0);
      tick();
      check("t2_xmit_W1", 32'(bus.input_transmit), 1);
`endif
      check("t2_dep_b",  32'(bus.depvals[1]), 32'h2A);
      check("t2_dep_a",  32'(bus.depvals[0]), 32'h01);
      check("t2_robid",  32'(bus.robid), 4);
      check("t2_flags",  32'(bus.flags), 32'h80);
      tick();

      // Fill to full while FU busy, then drain in order
      bus.fu_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_disp(8'h10, 2'b11, 4'h0, 4'h0, 8'(i), 8'(i + 1), 8'h30, 8'h00, 4'(8 + i));
         tick();
      end
      check("t3_count_full", 32'(bus.count), 4);
      check("t3_ready_full", 32'(bus.disp_ready), 0);
      set_disp(8'h10, 2'b11, 4'h0, 4'h0, 8'h0, 8'h0, 8'h30, 8'h00, 4'd12);
      tick();
      bus.disp_valid = 1'b0;
      check("t3_no_accept", 32'(bus.count), 4);
      check("t3_busy_hold", 32'(bus.input_transmit), 0);
      bus.fu_busy = 1'b0;
      k = 0;
      prev_x = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         check("t3_no_b2b", 32'(prev_x & bus.input_transmit), 0);
         if (bus.input_transmit) begin
            if (k < 4) check("t3_order", 32'(bus.robid), 32'(exp_ids[k]));
            else       check("t3_extra_issue", 32'(k), 3);
            k++;
         end
         prev_x = bus.input_transmit;
      end
      check("t3_issued", 32'(k), 4);
      check("t3_count_empty", 32'(bus.count), 0);

      // Younger ready entry bypasses older waiting one
      set_disp(8'h20, 2'b10, 4'd9, 4'h0, 8'h00, 8'h0B, 8'h40, 8'h00, 4'd1);
      tick();
      set_disp(8'h21, 2'b11, 4'h0, 4'h0, 8'h0C, 8'h0D, 8'h41, 8'h00, 4'd3);
      tick();
      bus.disp_valid = 1'b0;
      tick();
      check("t4_young_xmit", 32'(bus.input_transmit), 1);
      check("t4_young_id",   32'(bus.robid), 3);
      set_cdb(1'b1, 4'd9, 8'h55);
      tick();
      set_cdb(1'b0, 4'd0, 8'h00);
      check("t4_gap", 32'(bus.input_transmit), 0);
      tick();
      check("t4_old_xmit", 32'(bus.input_transmit), 1);
      check("t4_old_id",   32'(bus.robid), 1);
      check("t4_old_dep_a", 32'(bus.depvals[0]), 32'h55);
      check("t4_old_dep_b", 32'(bus.depvals[1]), 32'h0B);
      tick();

      // Dispatch/CDB race on src0
      set_disp(8'h30, 2'b10, 4'd3, 4'h0, 8'h00, 8'h02, 8'h50, 8'h00, 4'd7);
      set_cdb(1'b1, 4'd3, 8'h40);
      tick();
      bus.disp_valid = 1'b0;
      set_cdb(1'b0, 4'd0, 8'h00);
      check("t5_no_xmit_E", 32'(bus.input_transmit), 0);
      tick();
      check("t5_xmit",  32'(bus.input_transmit), 1);
      check("t5_dep_a", 32'(bus.depvals[0]), 32'h40);
      check("t5_robid", 32'(bus.robid), 7);
      tick();

      // Flush with 3 valid entries; a dispatch in the flush cycle is discarded
      bus.fu_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_disp(8'h40, 2'b11, 4'h0, 4'h0, 8'h01, 8'h02, 8'h60, 8'h00, 4'(i));
         tick();
      end
      check("t6_count3", 32'(bus.count), 3);
      bus.flush = 1'b1;
      bus.fu_busy = 1'b0;
      tick();
      bus.flush = 1'b0;
      bus.disp_valid = 1'b0;
      check("t6_flush_count", 32'(bus.count), 0);
      check("t6_flush_ready", 32'(bus.disp_ready), 1);
      check("t6_flush_xmit",  32'(bus.input_transmit), 0);
      tick();
      check("t6_after_flush_xmit", 32'(bus.input_transmit), 0);

      // Async reset while the strobe is high
      set_disp(8'h50, 2'b11, 4'h0, 4'h0, 8'h21, 8'h22, 8'h70, 8'h00, 4'd13);
      tick();
      bus.disp_valid = 1'b0;
      tick();
      check("t7_xmit",  32'(bus.input_transmit), 1);
      check("t7_robid", 32'(bus.robid), 13);
      #2;
      rst = 1'b0;
      #1;
      check("t7_rst_xmit",  32'(bus.input_transmit), 0);
      check("t7_rst_robid", 32'(bus.robid), 0);
      check("t7_rst_count", 32'(bus.count), 0);
      #2;
      rst = 1'b1;
      tick();
      check("t7_post_ready", 32'(bus.disp_ready), 1);
      check("t7_post_xmit",  32'(bus.input_transmit), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
